// File: rtl/regfile_hilo.sv
// regfile_hilo: MIPS architectural state -- 32x32 GPR file (r0 hardwired to
// zero), HI/LO pair, and registered commit-trace outputs for the lab trace
// comparator.
// Optional feature macro: REGFILE_BYPASS_EN selects write-first forwarding
// (a write presented this cycle is visible on the read ports in the same
// cycle). Without the macro, reads return the pre-edge value.
// Reset is asynchronous and active-high; every register clears immediately.
module regfile_hilo #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  // GPR write port (writeback stage)
  input  logic          rf_wvalid,
  input  logic [4:0]    rf_wid,
  input  logic [DW-1:0] rf_wdata,
  // GPR read ports (decode stage)
  input  logic [4:0]    ra1,
  input  logic [4:0]    ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  // HI/LO write and read
  input  logic          hi_wvalid,
  input  logic          lo_wvalid,
  input  logic [DW-1:0] hi_wdata,
  input  logic [DW-1:0] lo_wdata,
  output logic [DW-1:0] hi_rdata,
  output logic [DW-1:0] lo_rdata,
  // commit trace
  input  logic [31:0]   wpc,
  output logic [31:0]   debug_wb_pc,
  output logic [3:0]    debug_wb_rf_wen,
  output logic [4:0]    debug_wb_rf_wnum,
  output logic [DW-1:0] debug_wb_rf_wdata
);

  // Read-side view of the register file; entry 0 is a constant zero so that
  // r0 needs no storage and no special case in the read mux.
  logic [DW-1:0] rf_view [NREG];
  logic [DW-1:0] hi_q;
  logic [DW-1:0] lo_q;
  logic          commit_gpr;

  // A GPR write only commits (and only shows in the trace) for r1..r31.
  assign commit_gpr = rf_wvalid && (rf_wid != 5'd0);

  assign rf_view[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_reg
      logic [DW-1:0] q;

      // One storage register per GPR; loads when the write index selects it.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q <= '0;
        end else if (rf_wvalid && (rf_wid == 5'(gi))) begin
          q <= rf_wdata;
        end
      end

      assign rf_view[gi] = q;
    end
  endgenerate

  // HI register: updates only on its own valid (MTHI or mult/div result).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
    end else if (hi_wvalid) begin
      hi_q <= hi_wdata;
    end
  end

  // LO register: independent of HI so MTLO leaves HI untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q <= '0;
    end else if (lo_wvalid) begin
      lo_q <= lo_wdata;
    end
  end

  // Trace registers: capture the write committing on this edge, every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else begin
      debug_wb_pc       <= wpc;
      debug_wb_rf_wen   <= {4{commit_gpr}};
      debug_wb_rf_wnum  <= rf_wid;
      debug_wb_rf_wdata <= rf_wdata;
    end
  end

  // Combinational read ports, with optional same-cycle forwarding of the
  // incoming write (r0 never forwards since commit_gpr excludes it).
  always_comb begin
    rd1      = rf_view[ra1];
    rd2      = rf_view[ra2];
    hi_rdata = hi_q;
    lo_rdata = lo_q;
`ifdef REGFILE_BYPASS_EN
    if (commit_gpr && (rf_wid == ra1)) begin
      rd1 = rf_wdata;
    end
    if (commit_gpr && (rf_wid == ra2)) begin
      rd2 = rf_wdata;
    end
    if (hi_wvalid) begin
      hi_rdata = hi_wdata;
    end
    if (lo_wvalid) begin
      lo_rdata = lo_wdata;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_hilo.sv
// tb_regfile_hilo: directed plus randomized checks of regfile_hilo against a
// behavioural architectural-state model (array of 32 words, HI, LO, and the
// expected trace of the last committed write).
module tb_regfile_hilo;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rf_wvalid;
  logic [4:0]  rf_wid;
  logic [31:0] rf_wdata;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic        hi_wvalid, lo_wvalid;
  logic [31:0] hi_wdata, lo_wdata, hi_rdata, lo_rdata;
  logic [31:0] wpc;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  regfile_hilo #(.NREG(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .rf_wvalid(rf_wvalid), .rf_wid(rf_wid), .rf_wdata(rf_wdata),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .hi_wvalid(hi_wvalid), .lo_wvalid(lo_wvalid),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .hi_rdata(hi_rdata), .lo_rdata(lo_rdata),
    .wpc(wpc), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  // reference model
  logic [31:0] m_regs [32];
  logic [31:0] m_hi, m_lo;
  logic [31:0] e_pc, e_wdata;
  logic [3:0]  e_wen;
  logic [4:0]  e_wnum;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (BYPASS && rf_wvalid && rf_wid == ra) return rf_wdata;
    return m_regs[ra];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_hi = 0; m_lo = 0;
    e_pc = 0; e_wen = 0; e_wnum = 0; e_wdata = 0;
  endtask

  // check all combinational read outputs against the model for current inputs
  task automatic check_reads(input string tag);
    chk({tag, ".rd1"}, rd1, model_rd(ra1));
    chk({tag, ".rd2"}, rd2, model_rd(ra2));
    chk({tag, ".hi"}, hi_rdata, (BYPASS && hi_wvalid) ? hi_wdata : m_hi);
    chk({tag, ".lo"}, lo_rdata, (BYPASS && lo_wvalid) ? lo_wdata : m_lo);
  endtask

  task automatic check_trace(input string tag);
    chk({tag, ".pc"}, debug_wb_pc, e_pc);
    chk({tag, ".wen"}, {28'h0, debug_wb_rf_wen}, {28'h0, e_wen});
    chk({tag, ".wnum"}, {27'h0, debug_wb_rf_wnum}, {27'h0, e_wnum});
    chk({tag, ".wdata"}, debug_wb_rf_wdata, e_wdata);
  endtask

  // advance one edge, apply the committed writes to the model, check trace
  task automatic cycle(input string tag);
    @(posedge clk);
    n_cyc++;
    $display("cyc %0d %s: wv=%b wid=%0d wdata=%h hv=%b hd=%h lv=%b ld=%h pc=%h",
             n_cyc, tag, rf_wvalid, rf_wid, rf_wdata, hi_wvalid, hi_wdata,
             lo_wvalid, lo_wdata, wpc);
    if (!reset) begin
      if (rf_wvalid && rf_wid != 0) m_regs[rf_wid] = rf_wdata;
      if (hi_wvalid) m_hi = hi_wdata;
      if (lo_wvalid) m_lo = lo_wdata;
      e_pc    = wpc;
      e_wen   = (rf_wvalid && rf_wid != 0) ? 4'hf : 4'h0;
      e_wnum  = rf_wid;
      e_wdata = rf_wdata;
    end
    #1;
    check_trace(tag);
  endtask

  task automatic idle();
    rf_wvalid = 0; rf_wid = 0; rf_wdata = 0;
    hi_wvalid = 0; lo_wvalid = 0; hi_wdata = 0; lo_wdata = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    ra1 = 0; ra2 = 0; wpc = 0;
    model_clear();
    #2;
    // reset state: every index reads zero, trace zero
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      check_reads("rst_read");
    end
    check_trace("rst_trace");
    @(negedge clk);
    reset = 1'b0;

    // write r5 = deadbeef
    rf_wvalid = 1; rf_wid = 5; rf_wdata = 32'hdeadbeef; wpc = 32'hbfc0_0100;
    ra1 = 5; ra2 = 0;
    #1; check_reads("w5_same");
    cycle("w5");
    chk("w5.trace_wen", {28'h0, debug_wb_rf_wen}, 32'hf);
    idle();
    #1; chk("w5.rd1", rd1, 32'hdeadbeef);
    check_reads("w5_next");

    // write to r0 is dropped
    rf_wvalid = 1; rf_wid = 0; rf_wdata = 32'h12345678; wpc = 32'hbfc0_0104;
    ra1 = 0;
    #1; check_reads("w0_same");
    cycle("w0");
    chk("w0.trace_wen", {28'h0, debug_wb_rf_wen}, 32'h0);
    idle();
    #1; chk("w0.rd1", rd1, 32'h0);

    // same-cycle write/read of r7 on both ports
    rf_wvalid = 1; rf_wid = 7; rf_wdata = 32'h1; wpc = 32'hbfc0_0108;
    ra1 = 7; ra2 = 7;
    #1;
    chk("r7.rd1_same", rd1, BYPASS ? 32'h1 : 32'h0);
    chk("r7.rd2_same", rd2, BYPASS ? 32'h1 : 32'h0);
    cycle("w7");
    idle();
    #1; check_reads("r7_next");

    // HI/LO together, then LO alone
    hi_wvalid = 1; lo_wvalid = 1; hi_wdata = 32'hffff0000; lo_wdata = 32'h0000ffff;
    wpc = 32'hbfc0_010c;
    #1; check_reads("hilo_same");
    cycle("hilo");
    idle();
    #1;
    chk("hilo.hi", hi_rdata, 32'hffff0000);
    chk("hilo.lo", lo_rdata, 32'h0000ffff);
    lo_wvalid = 1; lo_wdata = 32'h5; wpc = 32'hbfc0_0110;
    #1; check_reads("lo_same");
    cycle("lo");
    idle();
    #1;
    chk("lo.hi_kept", hi_rdata, 32'hffff0000);
    chk("lo.lo", lo_rdata, 32'h5);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      rf_wvalid = ($urandom_range(0, 9) < 7);
      rf_wid    = 5'($urandom_range(0, 31));
      rf_wdata  = $urandom;
      hi_wvalid = ($urandom_range(0, 3) == 0);
      lo_wvalid = ($urandom_range(0, 3) == 0);
      hi_wdata  = $urandom;
      lo_wdata  = $urandom;
      wpc       = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? rf_wid : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? rf_wid : 5'($urandom_range(0, 31));
      #1; check_reads("rand");
      cycle("rand");
    end

    // asynchronous reset mid-cycle clears state before the next edge
    rf_wvalid = 1; rf_wid = 3; rf_wdata = 32'hA; wpc = 32'hbfc0_0200;
    hi_wvalid = 1; hi_wdata = 32'h77;
    cycle("w3");
    idle();
    ra1 = 3; ra2 = 5;
    #1; chk("ar.rd1_before", rd1, 32'hA);
    reset = 1'b1;
    #1;
    model_clear();
    chk("ar.rd1", rd1, 32'h0);
    check_reads("ar_read");
    check_trace("ar_trace");
    #1;
    reset = 1'b0;

    // traffic after reset
    for (int n = 0; n < 40; n++) begin
      rf_wvalid = 1'b1;
      rf_wid    = 5'($urandom_range(0, 31));
      rf_wdata  = $urandom;
      hi_wvalid = $urandom_range(0, 1) == 1;
      lo_wvalid = $urandom_range(0, 1) == 1;
      hi_wdata  = $urandom;
      lo_wdata  = $urandom;
      wpc       = $urandom;
      ra1 = rf_wid;
      ra2 = 5'($urandom_range(0, 31));
      #1; check_reads("post");
      cycle("post");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
